up_down_loadable_counter: RTL and testbench
===========================================

// Module: up_down_loadable_counter
// PURPOSE
//  Synchronous WIDTH-bit binary counter with parallel load and a run-time direction select.
//  General-purpose sequencing/timing primitive.
//  Loads a preset value from din, then counts up or down each clock, wrapping modulo 2^WIDTH.
// PARAMETERS
//  WIDTH  4  counter/data width in bits (legal range 2..32)
// PORTS
//  clk         in   1      single clock; all state changes on rising edge
//  rst         in   1      asynchronous, active-low reset (0 = reset asserted)
//  load        in   1      1 = load din into counter on next rising edge
//  mode_cntrl  in   1      direction: 1 = count up, 0 = count down
//  din         in   WIDTH  parallel preset value
//  dout        out  WIDTH  current count (registered output)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - rst=0: dout forced to 0 immediately, without waiting for a clock edge.
//  - While rst=0, dout holds 0 regardless of load, mode_cntrl and din.
//  - Reset release: the first rising edge with rst=1 applies the normal rules below.
//  - Priority at each rising edge with rst=1:
//    1. load=1: dout <= din; mode_cntrl ignored that cycle.
//    2. else mode_cntrl=1: dout <= dout + 1, modulo 2^WIDTH.
//    3. else: dout <= dout - 1, modulo 2^WIDTH.
//  - No hold/enable state: with load=0 the counter changes on every edge.
//  - Latency: load/mode changes sampled at edge N are visible on dout after edge N; no pipeline.
//  - Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1. Wrap is silent, no flag.
//  - Direction change mid-count: takes effect on the next edge; no glitch, no extra cycle.
//  - Simultaneous load and direction change: load wins; new direction applies from the following edge.
//  - Reset asserted mid-operation: count is lost; dout=0 until release.
//  - Inputs are assumed synchronous to clk (driven on the falling edge by benches); no internal synchronizers.
//  - No X propagation from dout after reset; all state bits are reset.
// STRUCTURE
//  - Single always block: async reset, else load / up / down.
//  - Shared package: constants DIR_UP=1'b1, DIR_DOWN=1'b0; default WIDTH constant.
//  - No sub-module needed. An optional next-value function (din / +1 / -1 mux) may live in the package.
// TESTING (WIDTH=4, 20 ns clock, stimulus on falling edge)
//  1. Pulse rst low for one cycle -> dout=0 asynchronously; stays 0 after release with load=0 and the default direction
//     (down counting then yields 15 on the next edge).
//  2. mode_cntrl=0, load din=3 for one cycle -> dout: 3, 2, 1, 0, 15 on successive edges.
//  3. mode_cntrl=1, load din=14 -> dout: 14, 15, 0, 1 (up wrap).
//  4. Counting up at 5, set mode_cntrl=0 -> next edge 6→ no: edge with mode=0 gives 4; then 3.
//  5. load=1 with mode_cntrl toggling, din=9 -> dout=9 regardless of mode; counting resumes next edge.
//  6. Assert rst=0 between edges while dout=7 -> dout=0 before the next clk edge; held while rst=0 even with load=1, din=12.

Source files
------------

// File: rtl/up_down_loadable_counter_pkg.sv
// Shared constants for the up/down loadable counter: direction encoding and default width.
package up_down_loadable_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/up_down_loadable_counter.sv
// WIDTH-bit binary counter with parallel load and run-time up/down select.
// Wraps modulo 2^WIDTH in both directions; load has priority over counting.
module up_down_loadable_counter
    import up_down_loadable_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode_cntrl,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Natural WIDTH-bit overflow/underflow provides the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end else if (mode_cntrl == DIR_UP) begin
            dout <= dout + ONE;
        end else begin
            dout <= dout - ONE;
        end
    end

endmodule

// File: tb/tb_up_down_loadable_counter.sv
// Directed bench for up_down_loadable_counter at WIDTH=4: reset, load, wrap, direction change.
module tb_up_down_loadable_counter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic         mode_cntrl;
    logic [W-1:0] din;
    logic [W-1:0] dout;

    int n_cmp  = 0;
    int n_fail = 0;

    up_down_loadable_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .mode_cntrl (mode_cntrl),
        .din        (din),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input logic [W-1:0] exp, input string tag);
        n_cmp++;
        assert (dout === exp) else begin
            n_fail++;
            $error("FAIL %s: dout=%0d expected %0d", tag, dout, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic md, input logic [W-1:0] d);
        @(negedge clk);
        rst        = r;
        load       = ld;
        mode_cntrl = md;
        din        = d;
    endtask

    task automatic tick_check(input logic [W-1:0] exp, input string tag);
        @(posedge clk);
        #1;
        check(exp, tag);
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        mode_cntrl = 1'b0;
        din        = '0;

        // 1. Asynchronous reset pulse, then default (down) counting wraps 0 -> 15
        #5 rst = 1'b0;
        #1 check(4'd0, "async_reset");
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        #1 check(4'd0, "reset_release_hold");
        tick_check(4'd15, "first_edge_down_wrap");

        // 2. Load 3, count down through zero
        drive(1'b1, 1'b1, 1'b0, 4'd3);
        tick_check(4'd3, "load3");
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick_check(4'd2, "down2");
        tick_check(4'd1, "down1");
        tick_check(4'd0, "down0");
        tick_check(4'd15, "down_wrap15");

        // 3. Load 14, count up through the top
        drive(1'b1, 1'b1, 1'b1, 4'd14);
        tick_check(4'd14, "load14");
        drive(1'b1, 1'b0, 1'b1, 4'd0);
        tick_check(4'd15, "up15");
        tick_check(4'd0, "up_wrap0");
        tick_check(4'd1, "up1");

        // 4. Direction change mid-count from 5
        drive(1'b1, 1'b1, 1'b1, 4'd5);
        tick_check(4'd5, "load5");
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick_check(4'd4, "dirchg_down4");
        tick_check(4'd3, "dirchg_down3");

        // 5. Load wins regardless of mode; new direction applies afterwards
        drive(1'b1, 1'b1, 1'b1, 4'd9);
        tick_check(4'd9, "load9_up");
        drive(1'b1, 1'b1, 1'b0, 4'd9);
        tick_check(4'd9, "load9_down");
        drive(1'b1, 1'b0, 1'b0, 4'd9);
        tick_check(4'd8, "resume_down8");
        drive(1'b1, 1'b0, 1'b1, 4'd9);
        tick_check(4'd9, "resume_up9");

        // 6. Reset mid-operation at 7, held while load=1 din=12
        drive(1'b1, 1'b1, 1'b1, 4'd7);
        tick_check(4'd7, "load7");
        drive(1'b0, 1'b1, 1'b1, 4'd12);
        #1 check(4'd0, "async_reset_mid");
        tick_check(4'd0, "reset_held_load");
        tick_check(4'd0, "reset_held_load2");
        drive(1'b1, 1'b1, 1'b0, 4'd12);
        tick_check(4'd12, "release_load12");
        drive(1'b1, 1'b0, 1'b0, 4'd12);
        tick_check(4'd11, "down11");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
